// File: rtl/accumulator_controller.sv
`default_nettype none
// ============================================================================
// accumulator_controller
//   Fetch/decode/execute sequencer driving the 8-bit accumulator datapath.
//   Revision: 1.0
// ============================================================================
module accumulator_controller #(
  parameter int addr_size = 5,
  parameter int data_size = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [data_size-1:0] MemData,
  input  logic                 Aeq0,
  input  logic                 Apos,
  input  logic                 Enter,
  output logic [addr_size-1:0] MemAddr,
  output logic                 MemWrite,
  output logic                 Aload,
  output logic [1:0]           Asel,
  output logic                 Sub,
  output logic                 Halted,
  output logic [2:0]           State
);

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_EXECUTE = 3'd2;
  localparam logic [2:0] S_INWAIT  = 3'd3;
  localparam logic [2:0] S_HALT    = 3'd4;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_IN    = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [1:0] SEL_MEM   = 2'b00;
  localparam logic [1:0] SEL_INPUT = 2'b10;
  localparam logic [1:0] SEL_ALU   = 2'b11;

  localparam logic [addr_size-1:0] PC_ONE = {{(addr_size-1){1'b0}}, 1'b1};

  logic [2:0]           state_q, state_d;
  logic [addr_size-1:0] pc_q, pc_d;
  logic [data_size-1:0] ir_q, ir_d;
  logic                 enter_prev_q, enter_prev_d;

  logic [2:0]           opcode;
  logic [addr_size-1:0] operand;
  logic                 enter_rise;

  assign opcode     = ir_q[data_size-1 -: 3];
  assign operand    = ir_q[addr_size-1:0];
  assign enter_rise = Enter & ~enter_prev_q;

  // EnterPrev resets high so an Enter held through reset release is not an edge.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q      <= S_FETCH;
      pc_q         <= '0;
      ir_q         <= '0;
      enter_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      enter_prev_q <= enter_prev_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    enter_prev_d = Enter;
    case (state_q)
      S_FETCH: begin
        ir_d    = MemData;
        pc_d    = pc_q + PC_ONE;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = (opcode == OP_HALT) ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
        state_d = S_FETCH;
        case (opcode)
          OP_IN:   state_d = S_INWAIT;
          OP_JZ:   if (Aeq0) pc_d = operand;
          OP_JPOS: if (Apos) pc_d = operand;
          default: ;
        endcase
      end
      S_INWAIT: begin
        if (enter_rise) state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_comb begin
    MemAddr  = operand;
    MemWrite = 1'b0;
    Aload    = 1'b0;
    Asel     = SEL_MEM;
    Sub      = 1'b0;
    Halted   = 1'b0;
    State    = state_q;
    case (state_q)
      S_FETCH: begin
        MemAddr = pc_q;
      end
      S_EXECUTE: begin
        case (opcode)
          OP_LOAD: begin
            Aload = 1'b1;
          end
          OP_STORE: begin
            MemWrite = 1'b1;
          end
          OP_ADD: begin
            Aload = 1'b1;
            Asel  = SEL_ALU;
          end
          OP_SUB: begin
            Aload = 1'b1;
            Asel  = SEL_ALU;
            Sub   = 1'b1;
          end
          default: ;
        endcase
      end
      S_INWAIT: begin
        if (enter_rise) begin
          Aload = 1'b1;
          Asel  = SEL_INPUT;
        end
      end
      S_HALT: begin
        Halted  = 1'b1;
        MemAddr = pc_q;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
